pair_scan_ctrl: RTL and testbench

Sequencer that owns a Moore "11"-pair detector and feeds it from a parallel word. Accepts a WIDTH-bit word on a start handshake, shifts it MSB-first through the detector one bit per clock, and counts every detected pair. It then holds the count on a valid/ready output until it is consumed. It sits between a parallel producer and the serial pair-detect datapath, so each word is scanned in isolation.

---
 rtl/pair_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_pair_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pair_scan_ctrl.sv
// Parallel-to-serial scan controller wrapping a Moore "11"-pair detector.
// Each accepted word is shifted MSB-first and its overlapping pairs are counted.
module pair_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             abort,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             busy,
  output logic             ser_bit,
  output logic             det,
  output logic             out_valid,
  output logic [CNT_W-1:0] pair_count
);

  localparam int BCNT_W = $clog2(WIDTH + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    D_ZERO = 2'd0,
    D_ONE  = 2'd1,
    D_PAIR = 2'd2
  } det_t;

  state_t             state_q, state_d;
  det_t               det_q, det_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cur_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      det_q     <= D_ZERO;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cur_bit = shreg_q[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;

    if (abort) begin
      state_d   = S_IDLE;
      det_d     = D_ZERO;
      shreg_d   = '0;
      bit_cnt_d = '0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_SHIFT;
            shreg_d   = data_in;
            bit_cnt_d = '0;
            det_d     = D_ZERO;   // pairs never span words
            cnt_d     = '0;
          end
        end

        S_SHIFT: begin
          if (!cur_bit) begin
            det_d = D_ZERO;
          end else begin
            case (det_q)
              D_ZERO:  det_d = D_ONE;
              D_ONE:   det_d = D_PAIR;
              D_PAIR:  det_d = D_PAIR;
              default: det_d = D_ZERO;
            endcase
          end
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (det_q == D_PAIR) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_FLUSH;
          end
        end

        // One extra edge so a pair completed by the last bit is counted.
        S_FLUSH: begin
          if (det_q == D_PAIR) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q == S_SHIFT) || (state_q == S_FLUSH);
  assign out_valid  = (state_q == S_DONE);
  assign ser_bit    = (state_q == S_SHIFT) && cur_bit;
  assign det        = (det_q == D_PAIR);
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_pair_scan_ctrl.sv
// Directed bench for pair_scan_ctrl: vector table of words with hand-derived
// detector traces and pair counts, plus back-pressure, abort and reset sequences.
module tb_pair_scan_ctrl;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  data_in;
  logic          abort;
  logic          out_ready;
  logic          in_ready;
  logic          busy;
  logic          ser_bit;
  logic          det;
  logic          out_valid;
  logic [CW-1:0] pair_count;

  int checks;
  int failures;

  typedef struct {
    logic [W-1:0]  data;
    logic [W-1:0]  det_mask;   // MSB = det after bit 0 consumed
    logic [CW-1:0] count;
  } vec_t;

  vec_t vecs[8];

  pair_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .abort      (abort),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .busy       (busy),
    .ser_bit    (ser_bit),
    .det        (det),
    .out_valid  (out_valid),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),   32'd1);
    chk({tag, ".busy"},       32'(busy),       32'd0);
    chk({tag, ".out_valid"},  32'(out_valid),  32'd0);
    chk({tag, ".pair_count"}, 32'(pair_count), 32'd0);
    chk({tag, ".ser_bit"},    32'(ser_bit),    32'd0);
    chk({tag, ".det"},        32'(det),        32'd0);
  endtask

  // Full scan with out_ready already high; checks every cycle of the trace.
  task automatic run_vec(input int idx);
    vec_t v;
    int   f0;
    v  = vecs[idx];
    f0 = failures;
    chk("idle.in_ready", 32'(in_ready), 32'd1);
    start     = 1'b1;
    data_in   = v.data;
    out_ready = 1'b1;
    tick();                                   // E0
    start   = 1'b0;
    data_in = '0;
    chk("accept.in_ready", 32'(in_ready), 32'd0);
    chk("accept.busy",     32'(busy),     32'd1);
    for (int i = 0; i < W; i++) begin
      chk("shift.ser_bit", 32'(ser_bit), 32'(v.data[W-1-i]));
      if (i == 0) chk("shift.det0", 32'(det), 32'd0);
      else        chk("shift.det",  32'(det), 32'(v.det_mask[W-i]));
      chk("shift.out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk("flush.busy",      32'(busy),      32'd1);
    chk("flush.ser_bit",   32'(ser_bit),   32'd0);
    chk("flush.det",       32'(det),       32'(v.det_mask[0]));
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    tick();                                   // E0+W+1
    chk("done.out_valid",  32'(out_valid),  32'd1);
    chk("done.busy",       32'(busy),       32'd0);
    chk("done.pair_count", 32'(pair_count), 32'(v.count));
    tick();                                   // E0+W+2
    chk("back.in_ready",   32'(in_ready),   32'd1);
    chk("back.out_valid",  32'(out_valid),  32'd0);
    $display("vec %0d data=%b count=%0d exp=%0d errors=%0d",
             idx, v.data, pair_count, v.count, failures - f0);
  endtask

  initial begin
    int saw_valid;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;

    vecs[0] = '{8'b1110_0110, 8'b0110_0010, 3'd3};
    vecs[1] = '{8'hFF,        8'b0111_1111, 3'd7};
    vecs[2] = '{8'h00,        8'b0000_0000, 3'd0};
    vecs[3] = '{8'hAA,        8'b0000_0000, 3'd0};
    vecs[4] = '{8'b0000_0011, 8'b0000_0001, 3'd1};
    vecs[5] = '{8'b0011_0110, 8'b0001_0010, 3'd2};
    vecs[6] = '{8'b0000_0001, 8'b0000_0000, 3'd0};
    vecs[7] = '{8'b1000_0000, 8'b0000_0000, 3'd0};

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      start   = ~start;
      abort   = ~abort;
      data_in = 8'hFF;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    chk_reset_outputs("rst_hold");
    $display("reset hold: in_ready=%0d busy=%0d out_valid=%0d", in_ready, busy, out_valid);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_release.in_ready", 32'(in_ready), 32'd1);

    // Vector table; vecs[6] and vecs[7] run back to back for isolation
    for (int k = 0; k < 8; k++) run_vec(k);

    // Back-pressure with start held high in DONE
    start     = 1'b1;
    data_in   = 8'b1110_0110;
    out_ready = 1'b0;
    tick();
    data_in = 8'h00;
    for (int i = 0; i < W + 1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid",  32'(out_valid),  32'd1);
      chk("bp.pair_count", 32'(pair_count), 32'd3);
      chk("bp.in_ready",   32'(in_ready),   32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_release.in_ready",  32'(in_ready),  32'd1);
    chk("bp_release.out_valid", 32'(out_valid), 32'd0);
    chk("bp_release.busy",      32'(busy),      32'd0);
    $display("backpressure: count held, released in_ready=%0d", in_ready);
    tick();

    // Abort in the 4th SHIFT cycle
    start   = 1'b1;
    data_in = 8'hFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_pre.busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_reset_outputs("abort");
    saw_valid = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (out_valid) saw_valid = 1;
      tick();
    end
    chk("abort.never_valid", 32'(saw_valid), 32'd0);
    $display("abort: in_ready=%0d pair_count=%0d saw_valid=%0d", in_ready, pair_count, saw_valid);

    // Asynchronous reset pulse mid-SHIFT
    start   = 1'b1;
    data_in = 8'hFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rstmid_pre.det",   32'(det),        32'd1);
    chk("rstmid_pre.count", 32'(pair_count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    $display("async reset mid-scan: busy=%0d det=%0d pair_count=%0d", busy, det, pair_count);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_mid_release.in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
